// File: rtl/lobster_lsu_sched.sv
// Load/store scheduler: in-order queue, one op outstanding on the memory port, load writeback.
// Request valid the cycle after capture into an empty queue; wb one cycle after mem_rvalid; in_ready drops when free < 2.
module lobster_lsu_sched #(
  parameter int ADDR_WIDTH = 36,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_load,
  input  logic [3:0]            in_size,
  input  logic [ADDR_WIDTH-1:0] in_addr0,
  input  logic [ADDR_WIDTH-1:0] in_addr1,
  input  logic [6:0]            in_rd0,
  input  logic [6:0]            in_rd1,
  input  logic [DATA_WIDTH-1:0] in_wdata0,
  input  logic [DATA_WIDTH-1:0] in_wdata1,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [6:0]            wb_sel,
  output logic [127:0]          wb_data,
  output logic                  busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ACCEPT_MAX = (PW+1)'(DEPTH - 2);

  typedef struct packed {
    logic                  load;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [6:0]            rd;
    logic [DATA_WIDTH-1:0] wdata;
  } op_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  function automatic logic [DATA_WIDTH-1:0] mask_data(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    case (size)
      2'b00:   m[7:0]  = '1;
      2'b01:   m[15:0] = '1;
      2'b10:   m[31:0] = '1;
      default: m       = '1;
    endcase
    return d & m;
  endfunction

  op_t           q [DEPTH];
  op_t           head, in_op0, in_op1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  state_t        state, state_nxt;
  logic          enq0, enq1, pop;
  logic [6:0]    out_rd;
  logic [1:0]    out_size;

  assign in_op0 = '{load: in_load[0], size: in_size[1:0], addr: in_addr0, rd: in_rd0, wdata: in_wdata0};
  assign in_op1 = '{load: in_load[1], size: in_size[3:2], addr: in_addr1, rd: in_rd1, wdata: in_wdata1};
  assign head   = q[rd_ptr];

  assign in_ready = (count <= ACCEPT_MAX);
  assign enq0     = in_ready && in_valid[0];
  assign enq1     = in_ready && in_valid[1];

  // Head is presented straight from the queue, so a fresh op can handshake while still in IDLE.
  assign mem_req_valid = (state == ISSUE) || ((state == IDLE) && (count != '0));
  assign pop           = mem_req_valid && mem_req_ready;
  assign mem_we        = mem_req_valid && !head.load;
  assign mem_size      = mem_req_valid ? head.size : '0;
  assign mem_addr      = mem_req_valid ? head.addr : '0;
  assign mem_wdata     = mem_we ? mask_data(head.size, head.wdata) : '0;

  assign wb_valid = (state == WB) && (wb_sel != '0);
  assign busy     = (count != '0) || (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ISSUE: begin
        if (pop)                state_nxt = head.load ? WAIT : IDLE;
        else if (mem_req_valid) state_nxt = ISSUE;
      end
      WAIT:    if (mem_rvalid) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq0) q[wr_ptr] <= in_op0;
    if (enq1) q[wr_ptr + PW'(enq0)] <= in_op1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_rd   <= '0;
      out_size <= '0;
      wb_sel   <= '0;
      wb_data  <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
      count  <= count + (PW+1)'(enq0) + (PW+1)'(enq1) - (PW+1)'(pop);
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_rd   <= head.rd;
        out_size <= head.size;
      end
      if (state == WAIT && mem_rvalid) begin
        wb_sel  <= out_rd;
        wb_data <= {{(128-DATA_WIDTH){1'b0}}, mask_data(out_size, mem_rdata)};
      end
    end
  end

endmodule

// File: tb/tb_lobster_lsu_sched.sv
// Directed bench for lobster_lsu_sched with request/writeback scoreboards and an automatic load responder.
module tb_lobster_lsu_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid;
  logic         in_ready;
  logic [1:0]   in_load;
  logic [3:0]   in_size;
  logic [35:0]  in_addr0, in_addr1;
  logic [6:0]   in_rd0, in_rd1;
  logic [63:0]  in_wdata0, in_wdata1;
  logic         mem_req_valid, mem_req_ready, mem_we;
  logic [1:0]   mem_size;
  logic [35:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;
  logic         wb_valid;
  logic [6:0]   wb_sel;
  logic [127:0] wb_data;
  logic         busy;

  lobster_lsu_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_size(in_size), .in_addr0(in_addr0), .in_addr1(in_addr1), .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_wdata0(in_wdata0), .in_wdata1(in_wdata1), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_sel(wb_sel), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [35:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct packed {
    logic [6:0]   sel;
    logic [127:0] data;
  } wbx_t;

  req_t        exp_req[$];
  wbx_t        exp_wb[$];
  logic [63:0] rdata_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, rv_cyc = -10, resp_delay = 0;
  int wb_seen = 0, wb_expected = 0;
  bit auto_resp = 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tmask(input logic [1:0] sz, input logic [63:0] d);
    int bits;
    bits = 8 << sz;
    return (sz == 2'b11) ? d : (d & ((64'd1 << bits) - 64'd1));
  endfunction

  // One clock: observe outputs at negedge, advance, then run the load responder at the drive point.
  task automatic cycle();
    req_t r;
    wbx_t w;
    @(negedge clk);
    if (!rst && mem_req_valid && mem_req_ready) begin
      check("req_expected", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) begin
        r = exp_req.pop_front();
        check("req_we", mem_we, r.we);
        check("req_size", mem_size, r.size);
        check("req_addr", mem_addr, r.addr);
        check("req_wdata", mem_wdata, r.wdata);
      end
      if (!mem_we && auto_resp) resp_delay = 2;
    end
    if (wb_valid) begin
      wb_seen++;
      check("wb_expected", exp_wb.size() != 0, 1);
      check("wb_latency", cyc, rv_cyc + 1);
      if (exp_wb.size() != 0) begin
        w = exp_wb.pop_front();
        check("wb_sel", wb_sel, w.sel);
        check("wb_data", wb_data, w.data);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (auto_resp) begin
      mem_rvalid = 1'b0;
      if (resp_delay > 0) begin
        resp_delay--;
        if (resp_delay == 0 && rdata_q.size() != 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata_q.pop_front();
          rv_cyc     = cyc;
        end
      end
    end
  endtask

  task automatic set_slot(input int s, input logic ld, input logic [1:0] sz, input logic [35:0] a,
                          input logic [6:0] rd, input logic [63:0] wd, input logic [63:0] rdat);
    in_load[s]        = ld;
    in_size[2*s +: 2] = sz;
    in_valid[s]       = 1'b1;
    if (s == 0) begin in_addr0 = a; in_rd0 = rd; in_wdata0 = wd; end
    else        begin in_addr1 = a; in_rd1 = rd; in_wdata1 = wd; end
    if (ld) begin
      exp_req.push_back('{we: 1'b0, size: sz, addr: a, wdata: 64'd0});
      rdata_q.push_back(rdat);
      if (rd != 7'd0) begin
        exp_wb.push_back('{sel: rd, data: {64'd0, tmask(sz, rdat)}});
        wb_expected++;
      end
    end else begin
      exp_req.push_back('{we: 1'b1, size: sz, addr: a, wdata: tmask(sz, wd)});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_req.size() != 0 || exp_wb.size() != 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", (exp_req.size() == 0 && exp_wb.size() == 0 && !busy), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = '0; in_load = '0; in_size = '0;
    in_addr0 = '0; in_addr1 = '0; in_rd0 = '0; in_rd1 = '0; in_wdata0 = '0; in_wdata1 = '0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) cycle();

    check("rst_req_valid", mem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_outs", {mem_we, mem_size, mem_addr, mem_wdata}, 0);
    check("rst_wb_outs", {wb_sel, wb_data}, 0);
    rst = 1'b0;
    cycle();

    // Single store, size 32b: upper wdata bits must be stripped.
    set_slot(0, 1'b0, 2'b10, 36'h100, 7'd0, 64'hFFFF_1234_5678, 64'd0);
    cycle();
    in_valid = '0;
    check("t1_req_valid", mem_req_valid, 1);
    check("t1_we", mem_we, 1);
    check("t1_wdata", mem_wdata, 64'h1234_5678);
    check("t1_busy", busy, 1);
    mem_req_ready = 1'b1;
    cycle();
    check("t1_busy_after", busy, 0);
    check("t1_req_valid_after", mem_req_valid, 0);

    // Byte load to r5.
    set_slot(0, 1'b1, 2'b00, 36'h20, 7'd5, 64'd0, 64'hAABB_CCDD);
    cycle();
    in_valid = '0;
    drain(30);

    // Store then load to the same address in one cycle.
    set_slot(0, 1'b0, 2'b11, 36'h40, 7'd0, 64'h0123_4567_89AB_CDEF, 64'd0);
    set_slot(1, 1'b1, 2'b01, 36'h40, 7'd9, 64'd0, 64'h1111_2222_3333_4444);
    cycle();
    in_valid = '0;
    drain(30);

    // Fill with memory stalled, hold a fifth pair, then release.
    mem_req_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < 2; s++) begin
        int i;
        i = 2 * p + s;
        set_slot(s, (i % 3) == 1, 2'(i % 4), 36'h1000 + 36'(i * 8), 7'(i + 10),
                 {$urandom, $urandom}, {$urandom, $urandom});
      end
      if (p == 4) begin
        repeat (3) begin
          cycle();
          check("t4_full_hold", in_ready, 0);
        end
        mem_req_ready = 1'b1;
      end
      n = 0;
      while (!in_ready && n < 50) begin cycle(); n++; end
      check("t4_in_ready_rise", in_ready, 1);
      cycle();
      in_valid = '0;
      if (p == 2) check("t4_free_two", in_ready, 1);
      if (p == 3) check("t4_full", in_ready, 0);
    end
    drain(200);

    // Load to r0: access performed, no writeback.
    set_slot(0, 1'b1, 2'b10, 36'h80, 7'd0, 64'd0, 64'h0000_DEAD_BEEF_0001);
    cycle();
    in_valid = '0;
    drain(30);

    // Reset while waiting for load data; late response must be dropped.
    auto_resp = 1'b0;
    mem_rvalid = 1'b0;
    set_slot(0, 1'b1, 2'b11, 36'h90, 7'd3, 64'd0, 64'd0);
    void'(rdata_q.pop_back());
    void'(exp_wb.pop_back());
    wb_expected--;
    cycle();
    in_valid = '0;
    cycle();
    check("t6_waiting_busy", busy, 1);
    check("t6_waiting_no_req", mem_req_valid, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h55;
    cycle();
    mem_rvalid = 1'b0;
    repeat (3) cycle();
    check("t6_no_wb", wb_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_req_valid", mem_req_valid, 0);
    check("t6_req_consumed", exp_req.size(), 0);

    check("wb_total", wb_seen, wb_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
